cvp14_mem_ctrl: RTL and testbench

- Downstream memory stage for the CVP14 vector core.
- Consumes the core's memory bus (Addr, RD, WR, data out) and returns read data on the core's DataIn.
- Holds an on-chip word-addressed 16-bit RAM.
- After reset, clears the RAM before serving accesses, accepts a testbench/program preload port, and keeps sticky error and access statistics for the instruction, VLD and VST streams.

---
 rtl/cvp14_mem_pkg.sv | 17 +
 rtl/cvp14_sram.sv | 32 +++
 rtl/cvp14_mem_ctrl.sv | 145 ++++++++++++++
 tb/tb_cvp14_mem_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cvp14_mem_pkg.sv
// Shared types and constants for the CVP14 downstream memory stage.
package cvp14_mem_pkg;

    // Controller state: zero the RAM after reset, then serve accesses.
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    // Positions of the sticky error bits in Err.
    localparam int ERR_RANGE   = 0;
    localparam int ERR_COLLIDE = 1;

    // Value written into every word while clearing.
    localparam logic [15:0] CLEAR_WORD = 16'h0000;

endpackage

// File: rtl/cvp14_sram.sv
// DEPTH x 16 single-write, single-registered-read RAM.
// The read register updates only when re is high, so it holds its value otherwise.
// A read and a write to the same word in one cycle return the old word.
module cvp14_sram #(
    parameter  int DEPTH  = 1024,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [15:0]       rdata,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [15:0]       wdata
);

    logic [15:0] mem [DEPTH];
    logic [15:0] rdata_q;

    // Array write and registered read; no reset so the array maps to block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/cvp14_mem_ctrl.sv
// CVP14 memory stage: clears the RAM after reset, then serves core reads and writes
// and preload writes. It keeps sticky range and collision errors and counts accepted accesses.
module cvp14_mem_ctrl
    import cvp14_mem_pkg::*;
#(
    parameter  int DEPTH  = 1024,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic        Clk1,
    input  logic        Reset,
    input  logic [15:0] Addr,
    input  logic        RD,
    input  logic        WR,
    input  logic [15:0] WrData,
    output logic [15:0] RdData,
    input  logic        LdEn,
    input  logic [15:0] LdAddr,
    input  logic [15:0] LdData,
    output logic        Ready,
    output logic [1:0]  Err,
    output logic [15:0] RdCount,
    output logic [15:0] WrCount
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clear_ptr_q, clear_ptr_d;
    logic [1:0]          err_q, err_d;
    logic [15:0]         rd_cnt_q, rd_cnt_d;
    logic [15:0]         wr_cnt_q, wr_cnt_d;
    // Forces RdData to zero after reset and after an out-of-range read.
    // The RAM read register is left untouched in both cases.
    logic                rd_zero_q, rd_zero_d;

    logic                mem_re;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [15:0]         mem_wdata;
    logic [15:0]         mem_rdata;

    logic                addr_ok;
    logic                ld_ok;
    logic                rd_only;
    logic                wr_only;

    // Zero-extend before comparing so DEPTH = 65536 needs no special case.
    assign addr_ok = ({16'd0, Addr} < 32'(DEPTH));
    assign ld_ok   = ({16'd0, LdAddr} < 32'(DEPTH));
    assign rd_only = RD & ~WR;
    assign wr_only = WR & ~RD;

    // Next-state, arbitration of the RAM write port, errors and counters.
    always_comb begin
        state_d     = state_q;
        clear_ptr_d = clear_ptr_q;
        err_d       = err_q;
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        rd_zero_d   = rd_zero_q;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = clear_ptr_q;
        mem_wdata   = CLEAR_WORD;
        unique case (state_q)
            CLEAR: begin
                mem_we      = 1'b1;
                clear_ptr_d = clear_ptr_q + 1'b1;
                if (clear_ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (RD && WR) begin
                    err_d[ERR_COLLIDE] = 1'b1;
                end
                if (rd_only) begin
                    rd_cnt_d = rd_cnt_q + 16'd1;
                    if (addr_ok) begin
                        mem_re    = 1'b1;
                        rd_zero_d = 1'b0;
                    end else begin
                        rd_zero_d        = 1'b1;
                        err_d[ERR_RANGE] = 1'b1;
                    end
                end
                if (wr_only) begin
                    if (LdEn) begin
                        err_d[ERR_COLLIDE] = 1'b1;
                    end else if (addr_ok) begin
                        mem_we    = 1'b1;
                        mem_waddr = Addr[ADDR_W-1:0];
                        mem_wdata = WrData;
                        wr_cnt_d  = wr_cnt_q + 16'd1;
                    end else begin
                        err_d[ERR_RANGE] = 1'b1;
                    end
                end
                // Preload owns the write port whenever it is active.
                if (LdEn && ld_ok) begin
                    mem_we    = 1'b1;
                    mem_waddr = LdAddr[ADDR_W-1:0];
                    mem_wdata = LdData;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // Control state registers with synchronous reset back to a fresh clear pass.
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            state_q     <= CLEAR;
            clear_ptr_q <= '0;
            err_q       <= 2'b00;
            rd_cnt_q    <= 16'd0;
            wr_cnt_q    <= 16'd0;
            rd_zero_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            clear_ptr_q <= clear_ptr_d;
            err_q       <= err_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_zero_q   <= rd_zero_d;
        end
    end

    cvp14_sram #(
        .DEPTH (DEPTH)
    ) u_sram (
        .clk   (Clk1),
        .re    (mem_re),
        .raddr (Addr[ADDR_W-1:0]),
        .rdata (mem_rdata),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata)
    );

    assign RdData  = rd_zero_q ? CLEAR_WORD : mem_rdata;
    assign Ready   = (state_q == RUN);
    assign Err     = err_q;
    assign RdCount = rd_cnt_q;
    assign WrCount = wr_cnt_q;

endmodule

// File: tb/tb_cvp14_mem_ctrl.sv
// Bench for cvp14_mem_ctrl.
// A behavioural model (plain array plus counters) is advanced every clock, and all
// outputs are compared after each edge. Directed steps and a randomized phase are used.
module tb_cvp14_mem_ctrl;

    localparam int DEPTH = 1024;

    logic        Clk1 = 1'b0;
    logic        Reset;
    logic [15:0] Addr;
    logic        RD;
    logic        WR;
    logic [15:0] WrData;
    logic [15:0] RdData;
    logic        LdEn;
    logic [15:0] LdAddr;
    logic [15:0] LdData;
    logic        Ready;
    logic [1:0]  Err;
    logic [15:0] RdCount;
    logic [15:0] WrCount;

    always #5 Clk1 = ~Clk1;

    cvp14_mem_ctrl #(.DEPTH(DEPTH)) dut (
        .Clk1    (Clk1),
        .Reset   (Reset),
        .Addr    (Addr),
        .RD      (RD),
        .WR      (WR),
        .WrData  (WrData),
        .RdData  (RdData),
        .LdEn    (LdEn),
        .LdAddr  (LdAddr),
        .LdData  (LdData),
        .Ready   (Ready),
        .Err     (Err),
        .RdCount (RdCount),
        .WrCount (WrCount)
    );

    // Reference model state.
    logic [15:0] m_mem [DEPTH];
    logic [15:0] m_rd;
    logic [1:0]  m_err;
    logic [15:0] m_rc;
    logic [15:0] m_wc;
    logic        m_ready;
    int          m_clear_left;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply the behavioural rules for one clock edge using the inputs present at that edge.
    task automatic model_edge();
        bit          a_ok;
        bit          l_ok;
        bit          do_wr;
        logic [15:0] wa;
        logic [15:0] wd;
        a_ok  = (int'(Addr) < DEPTH);
        l_ok  = (int'(LdAddr) < DEPTH);
        do_wr = 1'b0;
        wa    = Addr;
        wd    = WrData;
        if (Reset) begin
            m_clear_left = DEPTH;
            m_ready      = 1'b0;
            m_rd         = 16'h0;
            m_err        = 2'b00;
            m_rc         = 16'h0;
            m_wc         = 16'h0;
        end else if (!m_ready) begin
            m_clear_left--;
            if (m_clear_left == 0) begin
                for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'h0;
                m_ready = 1'b1;
            end
        end else begin
            if (RD && WR) begin
                m_err[1] = 1'b1;
            end else if (RD) begin
                m_rd = a_ok ? m_mem[int'(Addr)] : 16'h0;
                m_rc = m_rc + 16'd1;
                if (!a_ok) m_err[0] = 1'b1;
            end else if (WR) begin
                if (LdEn) m_err[1] = 1'b1;
                else if (a_ok) begin
                    do_wr = 1'b1;
                    m_wc  = m_wc + 16'd1;
                end else m_err[0] = 1'b1;
            end
            if (do_wr) m_mem[int'(wa)] = wd;
            if (LdEn && l_ok) m_mem[int'(LdAddr)] = LdData;
        end
    endtask

    // One clock: update the model at the edge, then compare every output shortly after.
    task automatic cyc();
        @(posedge Clk1);
        model_edge();
        #1;
        chk("ready",   {31'd0, Ready},   {31'd0, m_ready});
        chk("rddata",  {16'd0, RdData},  {16'd0, m_rd});
        chk("err",     {30'd0, Err},     {30'd0, m_err});
        chk("rdcount", {16'd0, RdCount}, {16'd0, m_rc});
        chk("wrcount", {16'd0, WrCount}, {16'd0, m_wc});
    endtask

    task automatic drive(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] wd,
                         input bit ld, input logic [15:0] la, input logic [15:0] ldd);
        RD = rd; WR = wr; Addr = a; WrData = wd; LdEn = ld; LdAddr = la; LdData = ldd;
        cyc();
    endtask

    task automatic idle();
        drive(0, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0);
    endtask

    task automatic rd_w(input logic [15:0] a);
        drive(1, 0, a, 16'h0, 0, 16'h0, 16'h0);
    endtask

    task automatic wr_w(input logic [15:0] a, input logic [15:0] d);
        drive(0, 1, a, d, 0, 16'h0, 16'h0);
    endtask

    task automatic ld_w(input logic [15:0] a, input logic [15:0] d);
        drive(0, 0, 16'h0, 16'h0, 1, a, d);
    endtask

    task automatic do_reset_and_clear();
        Reset = 1'b1;
        idle();
        Reset = 1'b0;
        repeat (DEPTH - 1) idle();
        chk("ready_low_before_last", {31'd0, Ready}, 32'd0);
        idle();
        chk("ready_after_depth", {31'd0, Ready}, 32'd1);
    endtask

    initial begin
        Reset = 1'b1; RD = 0; WR = 0; Addr = 0; WrData = 0; LdEn = 0; LdAddr = 0; LdData = 0;
        m_ready = 1'b0; m_clear_left = DEPTH; m_rd = 0; m_err = 0; m_rc = 0; m_wc = 0;

        // 1: reset, clear, first read.
        do_reset_and_clear();
        rd_w(16'h0005);
        idle();
        chk("p1_rddata", {16'd0, RdData}, 32'h0);
        chk("p1_rdcount", {16'd0, RdCount}, 32'd1);

        // 2: preload then read; held over idles.
        ld_w(16'h0010, 16'h1234);
        rd_w(16'h0010);
        chk("p2_rddata", {16'd0, RdData}, 32'h1234);
        repeat (3) idle();
        chk("p2_hold", {16'd0, RdData}, 32'h1234);

        // 3: core write, immediate read.
        wr_w(16'h0020, 16'hBEEF);
        rd_w(16'h0020);
        chk("p3_rddata", {16'd0, RdData}, 32'hBEEF);
        chk("p3_wrcount", {16'd0, WrCount}, 32'd1);

        // 4: 16-word preload then back-to-back burst read.
        for (int i = 0; i < 16; i++) ld_w(16'h0100 + 16'(i), 16'(i));
        for (int i = 0; i < 16; i++) begin
            rd_w(16'h0100 + 16'(i));
            chk("p4_burst", {16'd0, RdData}, i);
        end
        idle();

        // 5: out of range read and write.
        rd_w(16'h0400);
        chk("p5_rd_oor", {16'd0, RdData}, 32'h0);
        chk("p5_err", {30'd0, Err}, 32'd1);
        wr_w(16'h0400, 16'hFFFF);
        rd_w(16'h0000);
        chk("p5_no_wrap", {16'd0, RdData}, 32'h0);
        // Burst crossing the top of the array.
        for (int i = 0; i < 16; i++) rd_w(16'h03F8 + 16'(i));
        idle();
        chk("p5_err_sticky", {30'd0, Err}, 32'd1);

        // 6: collisions.
        wr_w(16'h0030, 16'h5555);
        drive(1, 1, 16'h0030, 16'hAAAA, 0, 16'h0, 16'h0);
        chk("p6_collide", {30'd0, Err}, 32'd3);
        rd_w(16'h0030);
        chk("p6_mem_unch", {16'd0, RdData}, 32'h5555);
        drive(0, 1, 16'h0031, 16'h1111, 1, 16'h0031, 16'h7777);
        rd_w(16'h0031);
        chk("p6_ld_wins", {16'd0, RdData}, 32'h7777);
        // Read and preload to the same word: read returns the old data.
        drive(1, 0, 16'h0031, 16'h0, 1, 16'h0031, 16'h9999);
        chk("p6_read_first", {16'd0, RdData}, 32'h7777);
        rd_w(16'h0031);
        chk("p6_ld_done", {16'd0, RdData}, 32'h9999);

        // Randomized mix against the model.
        for (int n = 0; n < 600; n++) begin
            logic [15:0] a;
            logic [15:0] la;
            a  = 16'($urandom_range(0, 40));
            la = 16'($urandom_range(0, 40));
            if ($urandom_range(0, 7) == 0) a  = a  + 16'd1000;
            if ($urandom_range(0, 7) == 0) la = la + 16'd1000;
            if ($urandom_range(0, 15) == 0) a = 16'hFFF0 + 16'($urandom_range(0, 15));
            drive($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, a, 16'($urandom),
                  $urandom_range(0, 4) == 0, la, 16'($urandom));
        end

        // Reset in the middle of a clear pass.
        Reset = 1'b1;
        idle();
        Reset = 1'b0;
        repeat (500) idle();
        do_reset_and_clear();
        chk("p6_err_cleared", {30'd0, Err}, 32'd0);
        chk("p6_rc_cleared", {16'd0, RdCount}, 32'd0);
        chk("p6_wc_cleared", {16'd0, WrCount}, 32'd0);
        rd_w(16'h0010);
        chk("p6_mem_cleared", {16'd0, RdData}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
